// File: rtl/async_fifo_package.sv
// async_fifo_package: shared pointer type, writer count and Gray-code helpers for the async FIFO
package async_fifo_package;

    localparam int NUM_WRITERS    = 2;
    localparam int ADDR_WIDTH_DEF = 4;

    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

    // Works for any width up to 32 when the unused upper bits are zero
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Upper zero bits leave the low-order result unaffected, so any width up to 32 works
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a Gray-coded bus crossing clock domains
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage shift into the local domain, cleared asynchronously
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= '0;
        else     {q, meta} <= {meta, d};

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side async FIFO controller with round-robin arbitration and full/count flags
module fifo_wr_ctrl
    import async_fifo_package::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_WRITERS-1:0] wr_req,
    input  logic [DATA_WIDTH-1:0]  wr_data0,
    input  logic [DATA_WIDTH-1:0]  wr_data1,
    output logic [NUM_WRITERS-1:0] wr_gnt,
    input  logic [ADDR_WIDTH:0]    rptr_gray,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_waddr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic [ADDR_WIDTH:0]    wptr_gray,
    output logic                   full,
    output logic                   almost_full,
    output logic [ADDR_WIDTH:0]    wr_count
);

    localparam int PW = ADDR_WIDTH + 1;
    // Inverts the top two bits of the read pointer; covers ADDR_WIDTH=1 where both bits flip
    localparam logic [ADDR_WIDTH:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

    logic [ADDR_WIDTH:0] wbin, wbin_next, wgray_next, rptr_sync, rbin_sync, fill;
    logic                last_gnt;
    logic                gnt_one;

    sync_2ff #(.WIDTH(PW)) u_rptr_sync (
        .clk (clk),
        .rst (~rst),
        .d   (rptr_gray),
        .q   (rptr_sync)
    );

    // Round-robin pick: a lone requester wins, contention goes to the one not served last
    always_comb begin
        gnt_one = (wr_req == 2'b11) ? ~last_gnt : wr_req[1];
        wr_gnt  = (rst && !full && |wr_req) ? (gnt_one ? 2'b10 : 2'b01) : 2'b00;
    end

    assign mem_we     = |wr_gnt;
    assign mem_waddr  = wbin[ADDR_WIDTH-1:0];
    assign mem_wdata  = wr_gnt[1] ? wr_data1 : wr_data0;
    assign wbin_next  = wbin + PW'(mem_we);
    assign wgray_next = PW'(bin2gray(32'(wbin_next)));
    assign rbin_sync  = PW'(gray2bin(32'(rptr_sync)));
    assign fill       = wbin_next - rbin_sync;

    // Pointer, flag and grant-history registers; flags look ahead at the post-write pointer
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_count    <= '0;
            last_gnt    <= 1'b1;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= wgray_next == (rptr_sync ^ FULL_MASK);
            almost_full <= 32'(fill) >= AFULL_THRESH;
            wr_count    <= fill;
            if (mem_we) last_gnt <= wr_gnt[1];
        end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: randomized and directed check of fifo_wr_ctrl against a write/read-count model
module tb_fifo_wr_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TH = 12;
    localparam int D  = 16;

    logic          clk = 0;
    logic          rst = 1;
    logic [1:0]    wr_req = 0;
    logic [DW-1:0] wr_data0 = 0, wr_data1 = 0;
    logic [AW:0]   rptr_gray = 0;
    logic [1:0]    wr_gnt;
    logic          mem_we, full, almost_full;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW:0]   wptr_gray, wr_count;

    fifo_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(TH)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_gnt(wr_gnt), .rptr_gray(rptr_gray), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .wptr_gray(wptr_gray), .full(full), .almost_full(almost_full),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // Model: total writes, total reads, read count as seen two edges late, registered flags
    int   m_w = 0, m_r = 0, p1 = 0, p2 = 0, m_cnt = 0;
    logic m_last = 1, m_full = 0, m_af = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [1:0] exp_gnt();
        if (m_full) return 2'b00;
        if (wr_req == 2'b11) return m_last ? 2'b01 : 2'b10;
        return wr_req;
    endfunction

    always @(posedge clk or negedge rst)
        if (!rst) begin
            m_w <= 0; p1 <= 0; p2 <= 0; m_cnt <= 0;
            m_full <= 0; m_af <= 0; m_last <= 1;
        end else begin : upd
            logic [1:0] g;
            int wn;
            g  = exp_gnt();
            wn = m_w + ((g != 0) ? 1 : 0);
            m_full <= (wn - p2) == D;
            m_af   <= (wn - p2) >= TH;
            m_cnt  <= wn - p2;
            if (g != 0) m_last <= g[1];
            m_w <= wn;
            p2  <= p1;
            p1  <= m_r;
        end

    always @(negedge clk)
        if (rst) begin : cmp
            logic [1:0] g;
            g = exp_gnt();
            chk("gnt", 32'(wr_gnt), 32'(g));
            chk("mem_we", 32'(mem_we), 32'(g != 0));
            chk("mem_waddr", 32'(mem_waddr), 32'(m_w % D));
            chk("mem_wdata", 32'(mem_wdata), 32'(g[1] ? wr_data1 : wr_data0));
            chk("wptr_gray", 32'(wptr_gray), 32'(gray(m_w)));
            chk("full", 32'(full), 32'(m_full));
            chk("almost_full", 32'(almost_full), 32'(m_af));
            chk("wr_count", 32'(wr_count), 32'(m_cnt));
        end

    task automatic cyc(input logic [1:0] req, input int rd);
        @(posedge clk); #1;
        wr_req    = req;
        wr_data0  = DW'($urandom);
        wr_data1  = DW'($urandom);
        m_r       = rd;
        rptr_gray = gray(rd);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 0; wr_req = 0; m_r = 0; rptr_gray = 0;
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 32'(wr_gnt), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_wptr"}, 32'(wptr_gray), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_afull"}, 32'(almost_full), 0);
        chk({tag, "_count"}, 32'(wr_count), 0);
    endtask

    initial begin
        #2 rst = 0;
        wr_req = 2'b11;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        wr_req = 0;
        rst = 1;

        for (int i = 0; i < 5; i++) begin
            cyc(2'b01, 0);
            @(negedge clk);
            chk("single_gnt", 32'(wr_gnt), 1);
            chk("single_addr", 32'(mem_waddr), i);
        end
        cyc(2'b00, 0);
        @(negedge clk);
        chk("single_wptr", 32'(wptr_gray), 32'b00111);
        chk("single_count", 32'(wr_count), 5);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, 0);
            @(negedge clk);
            chk("contend_gnt", 32'(wr_gnt), (i % 2) ? 2 : 1);
            chk("contend_data", 32'(mem_wdata), 32'((i % 2) ? wr_data1 : wr_data0));
        end

        do_reset();
        for (int i = 1; i <= 16; i++) begin
            cyc(2'($urandom_range(1, 3)), 0);
            @(negedge clk);
            chk("fill_afull", 32'(almost_full), 32'((i - 1) >= TH));
            chk("fill_full", 32'(full), 0);
        end
        cyc(2'b01, 0);
        @(negedge clk);
        chk("full_flag", 32'(full), 1);
        chk("full_count", 32'(wr_count), 16);
        chk("full_nogrant", 32'(wr_gnt), 0);

        cyc(2'b01, 1);
        @(negedge clk);
        chk("release_e0", 32'(full), 1);
        for (int e = 1; e <= 2; e++) begin
            @(negedge clk);
            chk("release_early", 32'(full), 1);
        end
        @(negedge clk);
        chk("release_full", 32'(full), 0);
        chk("release_count", 32'(wr_count), 15);
        chk("release_gnt", 32'(wr_gnt), 1);

        do_reset();
        for (int i = 0; i < 40; i++) begin
            cyc(2'b01, (m_w > 2) ? m_w - 2 : 0);
            @(negedge clk);
            chk("wrap_full", 32'(full), 0);
        end
        cyc(2'b00, 38);
        repeat (4) @(negedge clk);
        chk("wrap_wptr", 32'(wptr_gray), 32'b01100);
        chk("wrap_count", 32'(wr_count), 2);

        for (int i = 0; i < 400; i++)
            cyc(2'($urandom_range(0, 3)), (m_r < m_w && $urandom_range(0, 1) == 1) ? m_r + 1 : m_r);

        cyc(2'b11, m_r);
        #3 rst = 0;
        wr_req = 0; m_r = 0; rptr_gray = 0;
        #1 chk_zero("midrst");
        @(posedge clk); #1;
        rst = 1;
        cyc(2'b11, 0);
        @(negedge clk);
        chk("post_rst_gnt", 32'(wr_gnt), 1);
        cyc(2'b00, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
